// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with relative/absolute/conditional jumps and a LIFO return stack; ports clock, reset_n, enable, op, immediate, ZF, CF -> pc_value, top_of_stack, stack_count, stack_full, stack_empty, stack_error
module pc_stack_unit #(
  parameter int PC_WIDTH = 10,
  parameter int STACK_DEPTH = 4,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  localparam int CW = $clog2(STACK_DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [3:0]          op,
  input  logic [PC_WIDTH-1:0] immediate,
  input  logic                ZF,
  input  logic                CF,
  output logic [PC_WIDTH-1:0] pc_value,
  output logic [PC_WIDTH-1:0] top_of_stack,
  output logic [CW-1:0]       stack_count,
  output logic                stack_full,
  output logic                stack_empty,
  output logic                stack_error
);
  logic [PC_WIDTH-1:0] stack [STACK_DEPTH];
  logic [PC_WIDTH-1:0] seq, rel, nxt;
  logic taken, push, pop, err;
  assign seq = pc_value + PC_WIDTH'(1);
  assign rel = pc_value + immediate;
  assign stack_full = stack_count == CW'(STACK_DEPTH);
  assign stack_empty = stack_count == '0;
  assign top_of_stack = stack[0];
  always_comb begin
    taken = (op == 4'd1) | (op == 4'd2 & ZF & !CF) | (op == 4'd3 & !ZF & !CF) |
            (op == 4'd4 & !ZF & CF) | (op == 4'd5 & !CF) | (op == 4'd6 & ZF & CF);
    push = op == 4'd9 & !stack_full;
    pop = op == 4'd10 & !stack_empty;
    err = (op == 4'd9 & stack_full) | (op == 4'd10 & stack_empty);
    nxt = op == 4'd0 ? RESET_VECTOR :
          op == 4'd8 ? immediate :
          pop ? top_of_stack :
          (taken | push) ? rel : seq;
  end
  // Stack is a shift register with the top at index 0; unused slots are kept at
  // zero so top_of_stack reads 0 when empty.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_value <= RESET_VECTOR;
      stack_count <= '0;
      stack_error <= 1'b0;
      stack <= '{default: '0};
    end else if (enable) begin
      pc_value <= nxt;
      stack_error <= stack_error | err;
      if (push) begin
        stack_count <= stack_count + CW'(1);
        stack[0] <= seq;
        for (int i = 1; i < STACK_DEPTH; i++) stack[i] <= stack[i-1];
      end else if (pop) begin
        stack_count <= stack_count - CW'(1);
        for (int i = 0; i < STACK_DEPTH - 1; i++) stack[i] <= stack[i+1];
        stack[STACK_DEPTH-1] <= '0;
      end
    end
  end
endmodule

// File: doc/pc_stack_unit.md
PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 10, PC, immediate and stack-entry width (>=4).
REQ-002 SHALL have parameter STACK_DEPTH, default 4, number of return-address entries (>=1).
REQ-003 SHALL have parameter RESET_VECTOR, default 0, PC value after reset and after op RST.
REQ-004 SHALL have ports: clock  in  1  single clock, all state updates on rising edge.
REQ-005 SHALL have ports: reset_n  in  1  synchronous, active-low reset.
REQ-006 SHALL have ports: enable  in  1  advance/update when high, hold all state when low.
REQ-007 SHALL have ports: op  in  4  operation select (REQ-012).
REQ-008 SHALL have ports: immediate  in  PC_WIDTH  signed offset for relative ops, unsigned target for JABS.
REQ-009 SHALL have ports: ZF, CF  in  1 each  condition flags, sampled on the update edge.
REQ-010 SHALL have ports: pc_value  out  PC_WIDTH  registered PC; top_of_stack  out  PC_WIDTH  registered top entry, 0 when empty; stack_count  out  clog2(STACK_DEPTH+1)  entries held; stack_full, stack_empty  out  1  combinational from stack_count; stack_error  out  1  sticky overflow/underflow flag.

Function
REQ-011 SHALL update only on rising clock edges with reset_n high and enable high; with enable low, all outputs hold.
REQ-012 op encoding SHALL be: 0 RST (pc<=RESET_VECTOR, stack untouched); 1 JMP pc+imm; 2 JEQ if ZF&!CF; 3 JGT if !ZF&!CF; 4 JLT if !ZF&CF; 5 JGE if !CF; 6 JZC if ZF&CF; 7 NEXT pc+1; 8 JABS pc<=immediate; 9 CALL; 10 RET; 11-15 NEXT.
REQ-013 Conditional ops (2-6) SHALL load pc+immediate when the condition holds, else pc+1.
REQ-014 All PC arithmetic SHALL be modulo 2^PC_WIDTH, immediate sign-extended for relative ops; no overflow indication.
REQ-015 CALL with stack not full SHALL push pc+1 (mod 2^PC_WIDTH), load pc+immediate, increment stack_count, same cycle.
REQ-016 CALL with stack full SHALL not push, SHALL load pc+1, SHALL set stack_error.
REQ-017 RET with stack not empty SHALL load pc from top entry, pop it, decrement stack_count.
REQ-018 RET with stack empty SHALL load pc+1 and set stack_error; stack_count stays 0.
REQ-019 Stack SHALL be LIFO; top_of_stack SHALL reflect the new top in the cycle after push/pop.
REQ-020 stack_error SHALL stay 1 until reset; no other op clears it.
REQ-021 pc_value latency SHALL be one cycle: new value visible after the edge that samples op.
REQ-022 Non-stack ops SHALL leave stack contents, stack_count and stack_error unchanged.

Reset
REQ-023 On a rising edge with reset_n low: pc_value=RESET_VECTOR, stack_count=0, stack_empty=1, stack_full=0, top_of_stack=0, stack_error=0.
REQ-024 Reset SHALL take priority over enable and op, including mid CALL/RET; stack entry storage need not be cleared.

Verification
REQ-025 Reset then enable=1, op=7 for 3 cycles -> pc_value 0,1,2,3.
REQ-026 pc=5, op=1, imm=-6 (PC_WIDTH 10) -> pc_value=1023; then op=7 -> 0 (wrap).
REQ-027 pc=10, op=2 imm=4: ZF=1 CF=0 -> 14; ZF=1 CF=1 -> 11; op=6 with ZF=1 CF=1 -> pc+imm.
REQ-028 pc=20, CALL imm=10 -> pc=30, top_of_stack=21, count=1; RET -> pc=21, count=0, stack_empty=1.
REQ-029 STACK_DEPTH=4: 4 CALLs -> stack_full=1, error=0; 5th CALL -> pc+1, count=4, stack_error=1; 4 RETs return LIFO order; 5th RET -> pc+1, error still 1.
REQ-030 enable=0 with op=1 -> no change; reset_n=0 during CALL with enable=1 -> pc=RESET_VECTOR, count=0, error=0.
